// File: rtl/lh_frame_driver_pkg.sv
// ---------------------------------------------------------------------------
// lh_pkg : light_hash command codes and frame-driver FSM encoding
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lh_pkg;

  typedef enum logic [1:0] {
    CMD_HEAD    = 2'b00,
    CMD_TAIL    = 2'b01,
    CMD_MESSAGE = 2'b10,
    CMD_IDLE    = 2'b11
  } cmd_t;

  typedef enum logic [3:0] {
    FSM_IDLE     = 4'd0,
    FSM_HEAD     = 4'd1,
    FSM_HEAD_GAP = 4'd2,
    FSM_FETCH    = 4'd3,
    FSM_MSG      = 4'd4,
    FSM_MSG_WAIT = 4'd5,
    FSM_TAIL     = 4'd6,
    FSM_DIG_WAIT = 4'd7,
    FSM_OUT      = 4'd8
  } fsm_t;

endpackage

`default_nettype wire

// File: rtl/lh_frame_driver_if.sv
// ---------------------------------------------------------------------------
// lh_frame_driver_if : byte stream, light_hash command and digest handshakes
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface lh_frame_driver_if;

  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        in_ready;
  logic        message_valid;
  logic [1:0]  state;
  logic [7:0]  message_byte;
  logic        next_byte;
  logic [63:0] digest;
  logic        digest_ready;
  logic [63:0] out_digest;
  logic        out_valid;
  logic        out_ready;
  logic        err;

  // master is the frame driver itself
  modport master (
    input  in_valid, in_byte, in_last, next_byte, digest, digest_ready, out_ready,
    output in_ready, message_valid, state, message_byte, out_digest, out_valid, err
  );

  modport slave (
    output in_valid, in_byte, in_last, next_byte, digest, digest_ready, out_ready,
    input  in_ready, message_valid, state, message_byte, out_digest, out_valid, err
  );

endinterface

`default_nettype wire

// File: rtl/lh_frame_driver.sv
// ---------------------------------------------------------------------------
// lh_frame_driver : turns a byte stream into head/message/tail light_hash
//                   commands and returns the resulting digest. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lh_frame_driver
  import lh_pkg::*;
#(
  parameter int DIGEST_TIMEOUT = 1024,
  parameter int CNT_W          = 11
) (
  input  logic              clk,
  input  logic              rst,
  lh_frame_driver_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGEST_TIMEOUT - 1);

  fsm_t             fsm_q, fsm_d;
  logic [7:0]       msg_byte_q, msg_byte_d;
  logic             last_flag_q, last_flag_d;
  logic             wait_first_q, wait_first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      out_digest_q, out_digest_d;

  logic             message_valid;
  cmd_t             cmd;
  logic             in_ready;
  logic             out_valid;
  logic             err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q        <= FSM_IDLE;
      msg_byte_q   <= '0;
      last_flag_q  <= 1'b0;
      wait_first_q <= 1'b0;
      cnt_q        <= '0;
      out_digest_q <= '0;
    end else begin
      fsm_q        <= fsm_d;
      msg_byte_q   <= msg_byte_d;
      last_flag_q  <= last_flag_d;
      wait_first_q <= wait_first_d;
      cnt_q        <= cnt_d;
      out_digest_q <= out_digest_d;
    end
  end

  always_comb begin
    fsm_d         = fsm_q;
    msg_byte_d    = msg_byte_q;
    last_flag_d   = last_flag_q;
    wait_first_d  = wait_first_q;
    cnt_d         = cnt_q;
    out_digest_d  = out_digest_q;
    message_valid = 1'b0;
    cmd           = CMD_IDLE;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    err           = 1'b0;

    case (fsm_q)
      // the byte that wakes us up is only fetched after the head command
      FSM_IDLE: begin
        if (bus.in_valid) fsm_d = FSM_HEAD;
      end
      FSM_HEAD: begin
        message_valid = 1'b1;
        cmd           = CMD_HEAD;
        fsm_d         = FSM_HEAD_GAP;
      end
      FSM_HEAD_GAP: begin
        fsm_d = FSM_FETCH;
      end
      FSM_FETCH: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          msg_byte_d  = bus.in_byte;
          last_flag_d = bus.in_last;
          fsm_d       = FSM_MSG;
        end
      end
      FSM_MSG: begin
        message_valid = 1'b1;
        cmd           = CMD_MESSAGE;
        wait_first_d  = 1'b1;
        fsm_d         = FSM_MSG_WAIT;
      end
      // next_byte may not have risen yet in the first cycle after the strobe
      FSM_MSG_WAIT: begin
        wait_first_d = 1'b0;
        if (!wait_first_q && !bus.next_byte) begin
          fsm_d = last_flag_q ? FSM_TAIL : FSM_FETCH;
        end
      end
      FSM_TAIL: begin
        message_valid = 1'b1;
        cmd           = CMD_TAIL;
        cnt_d         = '0;
        fsm_d         = FSM_DIG_WAIT;
      end
      FSM_DIG_WAIT: begin
        if (bus.digest_ready) begin
          out_digest_d = bus.digest;
          fsm_d        = FSM_OUT;
        end else if (cnt_q == CNT_LAST) begin
          err   = 1'b1;
          fsm_d = FSM_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FSM_OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) fsm_d = FSM_IDLE;
      end
      default: begin
        fsm_d = FSM_IDLE;
      end
    endcase
  end

  assign bus.in_ready      = in_ready;
  assign bus.message_valid = message_valid;
  assign bus.state         = cmd;
  assign bus.message_byte  = msg_byte_q;
  assign bus.out_digest    = out_digest_q;
  assign bus.out_valid     = out_valid;
  assign bus.err           = err;

endmodule

`default_nettype wire

// File: doc/lh_frame_driver.md
LH_FRAME_DRIVER -- requirements
Module: lh_frame_driver

Interface
REQ-001 Parameter DIGEST_TIMEOUT, 1024, max cycles from tail command to digest_ready before error.
REQ-002 Parameter CNT_W, 11, width of timeout counter; SHALL satisfy 2^CNT_W > DIGEST_TIMEOUT.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  upstream byte valid.
REQ-006 in_byte  in  8  upstream message byte (ASCII).
REQ-007 in_last  in  1  marks final byte of a frame; qualified by in_valid.
REQ-008 in_ready  out  1  byte accepted when in_valid && in_ready.
REQ-009 message_valid  out  1  one-cycle command strobe to light_hash.
REQ-010 state  out  2  command code to light_hash: head / message / tail / idle.
REQ-011 message_byte  out  8  byte to light_hash; held stable from strobe until next_byte low.
REQ-012 next_byte  in  1  light_hash busy flag; high while a byte is being absorbed.
REQ-013 digest  in  64  light_hash result.
REQ-014 digest_ready  in  1  light_hash result valid.
REQ-015 out_digest  out  64  captured digest.
REQ-016 out_valid  out  1  out_digest valid; held until out_ready.
REQ-017 out_ready  in  1  downstream accepts digest.
REQ-018 err  out  1  one-cycle pulse on digest timeout.

Function
REQ-019 FSM states: IDLE, HEAD, HEAD_GAP, FETCH, MSG, MSG_WAIT, TAIL, DIG_WAIT, OUT.
REQ-020 IDLE: in_ready=0; on in_valid go to HEAD (byte not consumed).
REQ-021 HEAD: message_valid=1, state=head for exactly one cycle; then HEAD_GAP (one idle cycle, message_valid=0).
REQ-022 FETCH: in_ready=1; on accept latch in_byte into message_byte and in_last into last_flag, go to MSG; no accept -> remain.
REQ-023 MSG: message_valid=1, state=message, one cycle; then MSG_WAIT.
REQ-024 MSG_WAIT: minimum one cycle; leave only when next_byte==0 in a cycle after the first; to TAIL if last_flag else FETCH.
REQ-025 TAIL: message_valid=1, state=tail, one cycle; clear timeout counter; go to DIG_WAIT.
REQ-026 DIG_WAIT: capture digest into out_digest on first cycle with digest_ready=1, go to OUT; counter reaching DIGEST_TIMEOUT -> err pulse, out_digest unchanged, go to IDLE.
REQ-027 OUT: out_valid=1 until out_ready sampled high, then IDLE; in_ready=0 throughout (backpressure).
REQ-028 message_valid SHALL never be high on two consecutive cycles; state SHALL read idle (2'b11) whenever message_valid=0.
REQ-029 in_ready SHALL be high only in FETCH; at most one byte accepted per message command.
REQ-030 Frames have >=1 byte; in_last on first byte yields head, one message, tail.
REQ-031 Frame length unbounded; no internal byte count.

Reset
REQ-032 On rst: FSM=IDLE, message_valid=0, state=2'b11, message_byte=0, in_ready=0, out_valid=0, out_digest=0, err=0, counter=0, last_flag=0.
REQ-033 rst mid-frame SHALL abort immediately without a tail command; the next frame starts with a fresh head.

Structure
REQ-034 Shared package lh_pkg holds command codes HEAD=2'b00, TAIL=2'b01, MESSAGE=2'b10, IDLE=2'b11 and the FSM state enum.
REQ-035 Single module; no sub-module; timeout counter inline.

Verification
REQ-036 Frame "H4rdw4r3_Tr0j4n" into light_hash core -> out_digest=64'h5aecbf4f5fe467bc, out_valid high.
REQ-037 Frames "AlessandroAndGiacomo" then "3.141592653589793238" back-to-back -> 64'he19e79abcdf021f1 then 64'hf9e317d512022e21; each preceded by its own head.
REQ-038 Single byte 'A' with in_last -> exactly head, message(0x41), tail strobes, one cycle each, separated by idle cycles.
REQ-039 Stub holding next_byte high 20 cycles -> no in_ready and no message_valid during those cycles; next byte fetched after release.
REQ-040 Stub never asserting digest_ready -> err pulses once DIGEST_TIMEOUT (1024) cycles after tail, out_valid stays 0, FSM returns to IDLE.
REQ-041 rst asserted after 5th byte, out_ready held low in OUT for 10 cycles -> all outputs at reset values at once; out_valid held, in_ready 0 until accepted.
